s100_bus_cycle_gen: RTL and testbench

Converts the soft Z80's native bus strobes into properly sequenced S-100 status and control signals, replacing the faked pSYNC/pSTVAL/pDBIN and constant status lines in the T35 top level. Sits directly downstream of the Z80 core and drives the S-100 status and control buffers. Throttles the CPU through `z80_n_wait` until each S-100 cycle completes, and honours bus RDY/XRDY.

---
 rtl/s100_bus_pkg.sv | 46 ++++
 rtl/s100_sync2.sv | 27 ++
 rtl/s100_bus_cycle_gen.sv | 171 +++++++++++++++++
 tb/tb_s100_bus_cycle_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s100_bus_pkg.sv
// Shared types and index constants for the S-100 bus cycle generator.
// Status vectors and synchronised-input vectors are addressed through the constants below.
package s100_bus_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, STVAL, STROBE, DONE} bus_state_t;

  typedef enum logic [2:0] {MRD, FETCH, MWR, IOIN, IOOUT, INTA} cyc_type_t;

  localparam int STAT_MEMR = 0;
  localparam int STAT_M1   = 1;
  localparam int STAT_INP  = 2;
  localparam int STAT_OUT  = 3;
  localparam int STAT_MWRT = 4;
  localparam int STAT_INTA = 5;
  localparam int STAT_N_WO = 6;
  localparam int STAT_W    = 7;

  localparam int IN_XRDY   = 0;
  localparam int IN_RDY    = 1;
  localparam int IN_N_HALT = 2;
  localparam int IN_N_WR   = 3;
  localparam int IN_N_RD   = 4;
  localparam int IN_N_IORQ = 5;
  localparam int IN_N_MREQ = 6;
  localparam int IN_N_M1   = 7;
  localparam int IN_W      = 8;

  localparam int CNT_W = 4;

  function automatic logic [STAT_W-1:0] status_of(cyc_type_t t);
    logic [STAT_W-1:0] s;
    s = '0;
    s[STAT_N_WO] = 1'b1;
    case (t)
      MRD:   s[STAT_MEMR] = 1'b1;
      FETCH: begin s[STAT_MEMR] = 1'b1; s[STAT_M1] = 1'b1; end
      MWR:   begin s[STAT_MWRT] = 1'b1; s[STAT_N_WO] = 1'b0; end
      IOIN:  s[STAT_INP] = 1'b1;
      IOOUT: begin s[STAT_OUT] = 1'b1; s[STAT_N_WO] = 1'b0; end
      INTA:  begin s[STAT_M1] = 1'b1; s[STAT_INTA] = 1'b1; end
      default: s = s;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/s100_sync2.sv
// Two-flop synchroniser, one independent chain per bit.
// RST_VAL sets each chain to the input's inactive level so reset never fakes activity.
module s100_sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic [1:0] stage_reg;

    always_ff @(posedge clk) begin
      if (srst) begin
        stage_reg <= {2{RST_VAL[gi]}};
      end else begin
        stage_reg <= {stage_reg[0], d[gi]};
      end
    end

    assign q[gi] = stage_reg[1];
  end

endmodule

// File: rtl/s100_bus_cycle_gen.sv
// Turns Z80 strobes into sequenced S-100 status/control (SYNC, STVAL, strobe, done)
// and holds the CPU in WAIT until each bus cycle has completed.
module s100_bus_cycle_gen
  import s100_bus_pkg::*;
#(
  parameter int SYNC_CLKS       = 2,
  parameter int MIN_STROBE_CLKS = 2
) (
  input  logic pll0_2MHz,
  input  logic reset,
  input  logic cpu_n_m1,
  input  logic cpu_n_mreq,
  input  logic cpu_n_iorq,
  input  logic cpu_n_rd,
  input  logic cpu_n_wr,
  input  logic cpu_n_halt,
  input  logic s100_rdy,
  input  logic s100_xrdy,
  output logic s100_pSYNC,
  output logic s100_n_pSTVAL,
  output logic s100_pDBIN,
  output logic s100_n_pWR,
  output logic s100_sMEMR,
  output logic s100_sM1,
  output logic s100_sINP,
  output logic s100_sOUT,
  output logic s100_sMWRT,
  output logic s100_sINTA,
  output logic s100_sHLTA,
  output logic s100_n_sWO,
  output logic z80_n_wait,
  output logic bus_cycle_active
);

  logic [IN_W-1:0]   raw_in;
  logic [IN_W-1:0]   syn_in;
  logic              m1, mreq, iorq, rd, wr, rdy;
  logic              start;
  cyc_type_t         det_type, type_reg, type_next;
  bus_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              wait_reg, wait_next;
  logic              is_write;
  logic              in_strobe;
  logic [STAT_W-1:0] status;

  always_comb begin
    raw_in            = '0;
    raw_in[IN_N_M1]   = cpu_n_m1;
    raw_in[IN_N_MREQ] = cpu_n_mreq;
    raw_in[IN_N_IORQ] = cpu_n_iorq;
    raw_in[IN_N_RD]   = cpu_n_rd;
    raw_in[IN_N_WR]   = cpu_n_wr;
    raw_in[IN_N_HALT] = cpu_n_halt;
    raw_in[IN_RDY]    = s100_rdy;
    raw_in[IN_XRDY]   = s100_xrdy;
  end

  s100_sync2 #(
    .W       (IN_W),
    .RST_VAL ({IN_W{1'b1}})
  ) u_sync (
    .clk  (pll0_2MHz),
    .srst (reset),
    .d    (raw_in),
    .q    (syn_in)
  );

  assign m1   = ~syn_in[IN_N_M1];
  assign mreq = ~syn_in[IN_N_MREQ];
  assign iorq = ~syn_in[IN_N_IORQ];
  assign rd   = ~syn_in[IN_N_RD];
  assign wr   = ~syn_in[IN_N_WR];
  assign rdy  = syn_in[IN_RDY] & syn_in[IN_XRDY];

  // Read wins over write when both strobes are seen; bare mreq (refresh) is ignored.
  always_comb begin
    start    = 1'b1;
    det_type = MRD;
    if (mreq && rd && m1)  det_type = FETCH;
    else if (mreq && rd)   det_type = MRD;
    else if (mreq && wr)   det_type = MWR;
    else if (iorq && m1)   det_type = INTA;
    else if (iorq && rd)   det_type = IOIN;
    else if (iorq && wr)   det_type = IOOUT;
    else                   start    = 1'b0;
  end

  always_ff @(posedge pll0_2MHz) begin
    if (reset) begin
      state_reg <= IDLE;
      type_reg  <= MRD;
      cnt_reg   <= '0;
      wait_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      type_reg  <= type_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
    end
  end

  // cnt_reg counts clocks already spent in SYNC (from 0) or in STROBE (from 1).
  always_comb begin
    state_next = state_reg;
    type_next  = type_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        wait_next = 1'b1;
        if (start) begin
          state_next = SYNC;
          type_next  = det_type;
          wait_next  = 1'b0;
        end
      end
      SYNC: begin
        if (cnt_reg == CNT_W'(SYNC_CLKS - 1)) begin
          state_next = STVAL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STVAL: begin
        state_next = STROBE;
        cnt_next   = CNT_W'(1);
      end
      STROBE: begin
        if (cnt_reg >= CNT_W'(MIN_STROBE_CLKS) && rdy) begin
          state_next = DONE;
          wait_next  = 1'b1;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        wait_next = 1'b1;
        if (!rd && !wr && !iorq) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status            = '0;
    status[STAT_N_WO] = 1'b1;
    if (state_reg != IDLE) status = status_of(type_reg);
  end

  assign is_write  = (type_reg == MWR) || (type_reg == IOOUT);
  assign in_strobe = (state_reg == STROBE);

  assign s100_pSYNC       = (state_reg == SYNC);
  assign s100_n_pSTVAL    = (state_reg != STVAL);
  assign s100_pDBIN       = in_strobe && !is_write;
  assign s100_n_pWR       = !(in_strobe && is_write);
  assign s100_sMEMR       = status[STAT_MEMR];
  assign s100_sM1         = status[STAT_M1];
  assign s100_sINP        = status[STAT_INP];
  assign s100_sOUT        = status[STAT_OUT];
  assign s100_sMWRT       = status[STAT_MWRT];
  assign s100_sINTA       = status[STAT_INTA];
  assign s100_n_sWO       = status[STAT_N_WO];
  assign s100_sHLTA       = ~syn_in[IN_N_HALT];
  assign z80_n_wait       = wait_reg;
  assign bus_cycle_active = (state_reg != IDLE);

endmodule

// File: tb/tb_s100_bus_cycle_gen.sv
// Bench for s100_bus_cycle_gen: table-driven cycle types, hand-written corner cases,
// and randomized traffic compared every clock against a timeline-based reference model.
module tb_s100_bus_cycle_gen;

  localparam int S = 2;
  localparam int M = 2;
  localparam logic [13:0] RST_VEC = 14'b01010000000110;
  localparam logic [4:0]  CPU_IDLE = 5'b11111;

  localparam int K_NONE  = -1;
  localparam int K_MRD   = 0;
  localparam int K_FETCH = 1;
  localparam int K_MWR   = 2;
  localparam int K_IOIN  = 3;
  localparam int K_IOOUT = 4;
  localparam int K_INTA  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic n_m1, n_mreq, n_iorq, n_rd, n_wr, n_halt, rdy, xrdy;
  logic pSYNC, n_pSTVAL, pDBIN, n_pWR;
  logic sMEMR, sM1, sINP, sOUT, sMWRT, sINTA, sHLTA, n_sWO;
  logic n_wait, active;
  logic [13:0] act;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  s100_bus_cycle_gen #(.SYNC_CLKS(S), .MIN_STROBE_CLKS(M)) dut (
    .pll0_2MHz(clk), .reset(reset),
    .cpu_n_m1(n_m1), .cpu_n_mreq(n_mreq), .cpu_n_iorq(n_iorq),
    .cpu_n_rd(n_rd), .cpu_n_wr(n_wr), .cpu_n_halt(n_halt),
    .s100_rdy(rdy), .s100_xrdy(xrdy),
    .s100_pSYNC(pSYNC), .s100_n_pSTVAL(n_pSTVAL), .s100_pDBIN(pDBIN), .s100_n_pWR(n_pWR),
    .s100_sMEMR(sMEMR), .s100_sM1(sM1), .s100_sINP(sINP), .s100_sOUT(sOUT),
    .s100_sMWRT(sMWRT), .s100_sINTA(sINTA), .s100_sHLTA(sHLTA), .s100_n_sWO(n_sWO),
    .z80_n_wait(n_wait), .bus_cycle_active(active)
  );

  assign act = {pSYNC, n_pSTVAL, pDBIN, n_pWR, sMEMR, sM1, sINP, sOUT, sMWRT, sINTA,
                sHLTA, n_sWO, n_wait, active};

  // ---------------- reference model: cycle timeline measured from SYNC entry ----------------
  logic [7:0] mp1 = 8'hFF, mp2 = 8'hFF;  // {n_m1,n_mreq,n_iorq,n_rd,n_wr,n_halt,rdy,xrdy}
  bit   m_busy = 0, m_done = 0;
  int   m_e = 0, m_kind = K_MRD;
  logic m_wait = 1'b1;

  function automatic int classify(bit m1, bit mreq, bit iorq, bit rd, bit wr);
    if (mreq && rd) return m1 ? K_FETCH : K_MRD;
    if (mreq && wr) return K_MWR;
    if (iorq && m1) return K_INTA;
    if (iorq && rd) return K_IOIN;
    if (iorq && wr) return K_IOOUT;
    return K_NONE;
  endfunction

  function automatic logic [6:0] kind_status(int k);
    logic memr, m1s, inp, outp, mwrt, inta, wo_n;
    memr = (k == K_MRD) || (k == K_FETCH);
    m1s  = (k == K_FETCH) || (k == K_INTA);
    inp  = (k == K_IOIN);
    outp = (k == K_IOOUT);
    mwrt = (k == K_MWR);
    inta = (k == K_INTA);
    wo_n = !((k == K_MWR) || (k == K_IOOUT));
    return {memr, m1s, inp, outp, mwrt, inta, wo_n};
  endfunction

  task automatic model_step();
    logic [7:0] cur;
    bit m1, mreq, iorq, rd, wr, r;
    int k;
    cur  = {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_halt, rdy, xrdy};
    m1   = !mp2[7]; mreq = !mp2[6]; iorq = !mp2[5]; rd = !mp2[4]; wr = !mp2[3];
    r    = mp2[1] && mp2[0];
    if (reset) begin
      m_busy = 0; m_done = 0; m_e = 0; m_wait = 1'b1; mp1 = 8'hFF; mp2 = 8'hFF;
      return;
    end
    if (!m_busy) begin
      k = classify(m1, mreq, iorq, rd, wr);
      if (k != K_NONE) begin
        m_busy = 1; m_done = 0; m_e = 0; m_kind = k; m_wait = 1'b0;
      end
    end else if (m_done) begin
      if (!rd && !wr && !iorq) m_busy = 0;
    end else if (m_e > S && (m_e - S) >= M && r) begin
      m_done = 1; m_wait = 1'b1;
    end else begin
      m_e++;
    end
    mp2 = mp1;
    mp1 = cur;
  endtask

  function automatic logic [13:0] model_out();
    logic sync, stval, strobe, w;
    logic [6:0] st;
    sync   = m_busy && !m_done && (m_e < S);
    stval  = m_busy && !m_done && (m_e == S);
    strobe = m_busy && !m_done && (m_e > S);
    w      = (m_kind == K_MWR) || (m_kind == K_IOOUT);
    st     = m_busy ? kind_status(m_kind) : 7'b0000001;
    return {sync, !stval, strobe && !w, !(strobe && w), st[6:1], !mp2[2], st[0],
            m_wait, logic'(m_busy)};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) begin
      n_cmp++;
      if (act !== model_out()) begin
        n_err++;
        $display("FAIL model_cmp @%0t: got %b required %b", $time, act, model_out());
      end
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    int sync; int stval; int dbin; int wr; int wlow; int act; bit last_act;
    logic [6:0] stat; bit seen;
  } obs_t;

  typedef struct {
    string name; logic [4:0] cpu; logic [6:0] stat;
    int sync_len; int stval_len; int dbin_len; int wr_len; int wlow_len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic set_cpu(input logic [4:0] v);
    {n_m1, n_mreq, n_iorq, n_rd, n_wr} = v;
  endtask

  task automatic observe(input int n, inout obs_t o);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (pSYNC)    o.sync++;
      if (!n_pSTVAL) o.stval++;
      if (pDBIN)    o.dbin++;
      if (!n_pWR)   o.wr++;
      if (!n_wait)  o.wlow++;
      if (active)   o.act++;
      o.last_act = active;
      if (pSYNC && !o.seen) begin
        o.seen = 1;
        o.stat = {sMEMR, sM1, sINP, sOUT, sMWRT, sINTA, n_sWO};
      end
    end
  endtask

  task automatic wait_for(input string name, input int which);
    bit hit;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      case (which)
        0:       hit = (pSYNC === 1'b1);
        1:       hit = (n_pSTVAL === 1'b0);
        default: hit = (pDBIN === 1'b1);
      endcase
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s: got no event required within 20 clocks", name);
    end
  endtask

  task automatic rand_ready();
    rdy  = ($urandom_range(0, 4) != 0);
    xrdy = ($urandom_range(0, 4) != 0);
    if ($urandom_range(0, 15) == 0) n_halt = ~n_halt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    obs_t o;
    vecs[0] = '{"fetch",   5'b00101, 7'b1100001, 2, 1, 2, 0, 5};
    vecs[1] = '{"mem_rd",  5'b10101, 7'b1000001, 2, 1, 2, 0, 5};
    vecs[2] = '{"mem_wr",  5'b10110, 7'b0000100, 2, 1, 0, 2, 5};
    vecs[3] = '{"io_in",   5'b11001, 7'b0010001, 2, 1, 2, 0, 5};
    vecs[4] = '{"io_out",  5'b11010, 7'b0001000, 2, 1, 0, 2, 5};
    vecs[5] = '{"inta",    5'b01011, 7'b0100011, 2, 1, 2, 0, 5};
    vecs[6] = '{"rd_wr",   5'b10100, 7'b1000001, 2, 1, 2, 0, 5};
    vecs[7] = '{"refresh", 5'b10111, 7'b0000001, 0, 0, 0, 0, 0};

    reset = 1'b1; set_cpu(CPU_IDLE); n_halt = 1'b1; rdy = 1'b1; xrdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(act), 32'(RST_VEC));
    chk_en = 1;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      o = '{default: 0};
      @(negedge clk); set_cpu(vecs[i].cpu);
      observe(16, o);
      if (vecs[i].sync_len != 0)
        check({vecs[i].name, "_status"}, 32'(o.stat), 32'(vecs[i].stat));
      check({vecs[i].name, "_psync_len"},  o.sync,  vecs[i].sync_len);
      check({vecs[i].name, "_pstval_len"}, o.stval, vecs[i].stval_len);
      check({vecs[i].name, "_pdbin_len"},  o.dbin,  vecs[i].dbin_len);
      check({vecs[i].name, "_pwr_len"},    o.wr,    vecs[i].wr_len);
      check({vecs[i].name, "_wait_low"},   o.wlow,  vecs[i].wlow_len);
      @(negedge clk); set_cpu(CPU_IDLE);
      o = '{default: 0};
      observe(5, o);
      check({vecs[i].name, "_back_idle"}, 32'(o.last_act), 0);
    end

    // HALT status follows the synchronised pin while a fetch runs
    @(negedge clk); set_cpu(5'b00101); n_halt = 1'b0;
    @(posedge clk); #1;
    check("halt_after_1clk", 32'(sHLTA), 0);
    repeat (2) @(posedge clk); #1;
    check("halt_after_3clk", 32'(sHLTA), 1);
    check("halt_fetch_sM1", 32'(sM1), 1);
    o = '{default: 0}; observe(8, o);
    @(negedge clk); set_cpu(CPU_IDLE); n_halt = 1'b1;
    o = '{default: 0}; observe(5, o);

    // reset while strobing, then a clean cycle afterwards
    @(negedge clk); set_cpu(5'b10101);
    wait_for("rst_reach_strobe", 2);
    @(negedge clk); reset = 1'b1; set_cpu(CPU_IDLE);
    @(posedge clk); #1;
    check("reset_midcycle", 32'(act), 32'(RST_VEC));
    @(negedge clk); reset = 1'b0;
    o = '{default: 0}; observe(4, o);
    check("post_reset_quiet", o.act, 0);
    @(negedge clk); set_cpu(5'b10101);
    o = '{default: 0}; observe(12, o);
    check("post_reset_psync", o.sync, 2);
    check("post_reset_pdbin", o.dbin, 2);
    @(negedge clk); set_cpu(CPU_IDLE);
    o = '{default: 0}; observe(5, o);

    // XRDY low for 10 clocks starting in STVAL stretches pDBIN to 12 clocks
    @(negedge clk); set_cpu(5'b10101);
    wait_for("xrdy_reach_stval", 1);
    o = '{default: 0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0)  xrdy = 1'b0;
      if (i == 10) xrdy = 1'b1;
      observe(1, o);
    end
    check("xrdy_pdbin_len", o.dbin, 12);
    check("xrdy_wait_low", o.wlow, 12);
    @(negedge clk); set_cpu(CPU_IDLE);
    o = '{default: 0}; observe(5, o);

    // CPU drops its write strobe during SYNC: sequence completes, DONE exits at once
    @(negedge clk); set_cpu(5'b10110);
    wait_for("abort_reach_sync", 0);
    @(negedge clk); set_cpu(CPU_IDLE);
    o = '{default: 0}; observe(12, o);
    check("abort_active_len", o.act + 1, 6);
    check("abort_pwr_len", o.wr, 2);
    check("abort_wait_low", o.wlow + 1, 5);

    // randomized traffic, checked every clock by the model
    for (int it = 0; it < 150; it++) begin
      int gap, hold, k;
      gap  = $urandom_range(0, 3);
      hold = $urandom_range(1, 14);
      k    = $urandom_range(0, 7);
      repeat (gap) begin @(negedge clk); rand_ready(); end
      @(negedge clk); set_cpu(vecs[k].cpu); rand_ready();
      repeat (hold) begin
        @(negedge clk); rand_ready();
        reset = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk); set_cpu(CPU_IDLE); reset = 1'b0;
      repeat (8) begin @(negedge clk); rand_ready(); end
      @(negedge clk); rdy = 1'b1; xrdy = 1'b1;
      repeat (6) @(negedge clk);
    end
    n_halt = 1'b1;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
